string_led_sequencer: RTL

Serial LED-string driver sitting directly downstream of the Wishbone register block and the pixel SRAM in the gonso user area. On a start strobe it walks the SRAM pixel bytes from `w_first` to `w_last`, serialises each byte MSB-first onto a single one-wire LED data line using 3-tick NRZ symbols timed by a programmable prescaler, repeats the pass `w_count+1` times, then emits a latch gap. It drives the SRAM read port (port 1) and reports `progress` back to the register block, whose falling edge raises the IRQ.

---
 rtl/string_led_pkg.sv | 27 ++
 rtl/string_led_tick_gen.sv | 37 +++
 rtl/string_led_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/string_led_pkg.sv
// Shared definitions for the serial LED-string sequencer.
// Contents: FSM state enum, symbol geometry constants and the
// symbol line-level helper.
package string_led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  localparam int unsigned TICKS_PER_BIT   = 3;
  localparam int unsigned BITS_PER_BYTE   = 8;
  localparam int unsigned BIT1_HIGH_TICKS = 2;
  localparam int unsigned BIT0_HIGH_TICKS = 1;

  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned BIT_IDX_W = 3;

  // Line level (before polarity) for a given data bit during symbol phase.
  function automatic logic sym_level(input logic bit_val, input logic [PHASE_W-1:0] phase);
    return (32'(phase) < (bit_val ? BIT1_HIGH_TICKS : BIT0_HIGH_TICKS));
  endfunction

endpackage

// File: rtl/string_led_tick_gen.sv
// Prescaler tick generator: counts 0..prescaler and flags the cycle the
// count equals prescaler. tick is registered from the next-cycle count so
// it lines up with the counter value it describes.
// Ports: clk, rst_n (sync, active-low), clear (sync clear of the counter),
//        prescaler (tick period minus one), tick (one-cycle tick flag).
module string_led_tick_gen #(
  parameter int unsigned PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [PSIZE-1:0] prescaler,
  output logic             tick
);

  logic [PSIZE-1:0] cnt;
  logic [PSIZE-1:0] cnt_next;

  // Next count: cleared on request, wraps after reaching prescaler.
  always_comb begin
    cnt_next = cnt + PSIZE'(1);
    if (clear || (cnt == prescaler)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == prescaler);
    end
  end

endmodule

// File: rtl/string_led_sequencer.sv
// One-wire LED-string driver. Walks pixel SRAM bytes w_first..w_last,
// sends each MSB-first as 3-tick NRZ symbols, repeats w_count+1 passes,
// then holds a low latch gap of LATCH_TICKS ticks.
// Ports: clk, rst_n (sync, active-low), controller_en, prescaler, polarity,
//        w_count, w_first, w_last, start (inputs); progress, cs_n, addr,
//        led_out (registered outputs); rdata (SRAM port-1 read data).
// Build option: STRING_LED_LOOP_EN makes w_count=15 loop passes forever.
module string_led_sequencer
  import string_led_pkg::*;
#(
  parameter int unsigned ASIZE       = 32,
  parameter int unsigned PSIZE       = 32,
  parameter int unsigned LATCH_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             controller_en,
  input  logic [PSIZE-1:0] prescaler,
  input  logic             polarity,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             led_out
);

  localparam int unsigned LATCH_W = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  state_t                 state, state_n;
  logic [ASIZE-1:0]       addr_n, byte_addr, byte_addr_n, nxt_addr;
  logic [3:0]             pass_cnt, pass_n;
  logic [7:0]             shift_reg, shift_n, next_byte, next_byte_n;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [PHASE_W-1:0]     phase, phase_n;
  logic [LATCH_W-1:0]     latch_cnt, latch_n;
  logic                   line_lvl, line_n;
  logic                   cs_n_n, progress_n;
  logic                   pf_capture, pf_capture_n;
  logic                   tick, tick_clr;
  logic                   single, more_bytes, more_after, more_passes;

  // Counter runs only while symbols or latch ticks are being timed.
  assign tick_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

  string_led_tick_gen #(
    .PSIZE(PSIZE)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tick_clr),
    .prescaler(prescaler),
    .tick     (tick)
  );

  // Window bookkeeping: a reversed window degenerates to w_first only.
  assign single     = (w_last < w_first);
  assign nxt_addr   = byte_addr + ASIZE'(1);
  assign more_bytes = !single && (byte_addr != w_last);
  assign more_after = !single && (nxt_addr != w_last);

`ifdef STRING_LED_LOOP_EN
  assign more_passes = (w_count == 4'hF) || (pass_cnt != w_count);
`else
  assign more_passes = (pass_cnt != w_count);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    addr_n       = addr;
    byte_addr_n  = byte_addr;
    pass_n       = pass_cnt;
    shift_n      = shift_reg;
    next_byte_n  = next_byte;
    bit_idx_n    = bit_idx;
    phase_n      = phase;
    latch_n      = latch_cnt;
    line_n       = line_lvl;
    cs_n_n       = 1'b1;
    pf_capture_n = (state == SHIFT) && !cs_n;

    // Prefetched byte arrives the cycle after its chip-select pulse.
    if (pf_capture) begin
      next_byte_n = rdata;
    end

    case (state)
      IDLE: begin
        line_n = 1'b0;
        if (start) begin
          state_n     = FETCH;
          addr_n      = w_first;
          byte_addr_n = w_first;
          pass_n      = 4'd0;
          cs_n_n      = 1'b0;
        end
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        state_n   = SHIFT;
        shift_n   = rdata;
        bit_idx_n = '0;
        phase_n   = '0;
        line_n    = 1'b1;
        if (more_bytes) begin
          cs_n_n = 1'b0;
          addr_n = nxt_addr;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (phase != PHASE_W'(TICKS_PER_BIT - 1)) begin
            phase_n = phase + PHASE_W'(1);
            line_n  = sym_level(shift_reg[7], phase + PHASE_W'(1));
          end else if (bit_idx != BIT_IDX_W'(BITS_PER_BYTE - 1)) begin
            phase_n   = '0;
            bit_idx_n = bit_idx + BIT_IDX_W'(1);
            shift_n   = {shift_reg[6:0], 1'b0};
            line_n    = 1'b1;
          end else if (more_bytes) begin
            // Back-to-back byte: no gap, prefetch the one after if any.
            phase_n     = '0;
            bit_idx_n   = '0;
            shift_n     = next_byte;
            byte_addr_n = nxt_addr;
            line_n      = 1'b1;
            if (more_after) begin
              cs_n_n = 1'b0;
              addr_n = nxt_addr + ASIZE'(1);
            end
          end else if (more_passes) begin
            state_n     = FETCH;
            addr_n      = w_first;
            byte_addr_n = w_first;
            pass_n      = pass_cnt + 4'd1;
            cs_n_n      = 1'b0;
            line_n      = 1'b0;
          end else begin
            state_n = LATCH;
            latch_n = '0;
            line_n  = 1'b0;
          end
        end
      end
      LATCH: begin
        line_n = 1'b0;
        if (tick) begin
          if (latch_cnt == LATCH_W'(LATCH_TICKS - 1)) begin
            state_n = IDLE;
          end else begin
            latch_n = latch_cnt + LATCH_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b0;
      end
    endcase

    // Disable aborts from any state on the next edge.
    if (!controller_en) begin
      state_n = IDLE;
      cs_n_n  = 1'b1;
      line_n  = 1'b0;
    end

    progress_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      byte_addr  <= '0;
      pass_cnt   <= 4'd0;
      shift_reg  <= 8'd0;
      next_byte  <= 8'd0;
      bit_idx    <= '0;
      phase      <= '0;
      latch_cnt  <= '0;
      line_lvl   <= 1'b0;
      cs_n       <= 1'b1;
      progress   <= 1'b0;
      pf_capture <= 1'b0;
      led_out    <= polarity;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      byte_addr  <= byte_addr_n;
      pass_cnt   <= pass_n;
      shift_reg  <= shift_n;
      next_byte  <= next_byte_n;
      bit_idx    <= bit_idx_n;
      phase      <= phase_n;
      latch_cnt  <= latch_n;
      line_lvl   <= line_n;
      cs_n       <= cs_n_n;
      progress   <= progress_n;
      pf_capture <= pf_capture_n;
      led_out    <= line_n ^ polarity;
    end
  end

endmodule
